// File: rtl/key_entry_pkg.sv
// rtl/key_entry_pkg.sv - shared types, BCD/time limits and helpers for the keypad entry buffer
package key_entry_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ENTRY = 1'b1
  } state_t;

  localparam int unsigned BCD_MAX            = 9;
  localparam int unsigned HR_TENS_MAX        = 2;
  localparam int unsigned HR_UNITS_MAX_AT_20 = 3;
  localparam int unsigned MIN_TENS_MAX       = 5;

  function automatic logic is_bcd(input int unsigned d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/key_entry_buffer_if.sv
// rtl/key_entry_buffer_if.sv - keypad-side strobes and load-side results of the entry buffer
interface key_entry_buffer_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic [DIGIT_W-1:0]            key;
  logic                          key_valid;
  logic                          backspace;
  logic                          clear;
  logic                          commit;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic [CNT_W-1:0]              count;
  logic                          entry_active;
  logic                          load_valid;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_digits;
  logic                          error;
  logic                          timeout;

  modport master (
    output key, key_valid, backspace, clear, commit,
    input  digits, count, entry_active, load_valid, load_digits, error, timeout
  );

  modport slave (
    input  key, key_valid, backspace, clear, commit,
    output digits, count, entry_active, load_valid, load_digits, error, timeout
  );

endinterface

// File: rtl/key_entry_timer.sv
// rtl/key_entry_timer.sv - inactivity counter; expire is high in the last idle cycle of the window
module key_entry_timer #(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expire
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || restart || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + TW'(1);
    end
  end

  // A strobe in the expiry cycle wins over the abort.
  assign expire = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/key_entry_buffer.sv
// rtl/key_entry_buffer.sv - BCD digit-entry buffer with backspace, clear, timeout and validated commit
// Optional HH:MM commit check when TIME_RANGE_CHECK_EN is defined (NUM_DIGITS == 4 only).
module key_entry_buffer
  import key_entry_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input logic               clk,
  input logic               reset,
  key_entry_buffer_if.slave kb
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_DIGITS);

  state_t                             state;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] load_q;
  logic [CNT_W-1:0]                   count_q;
  logic                               load_valid_q;
  logic                               error_q;
  logic                               timeout_q;
  logic                               any_strobe;
  logic                               expire;
  logic                               range_ok;

  assign any_strobe = kb.key_valid | kb.backspace | kb.clear | kb.commit;

  key_entry_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(any_strobe),
    .enable (state == ENTRY),
    .expire (expire)
  );

`ifdef TIME_RANGE_CHECK_EN
  if (NUM_DIGITS == 4) begin : g_range
    assign range_ok = (32'(digit_q[3]) <= HR_TENS_MAX) &&
                      ((32'(digit_q[3]) != HR_TENS_MAX) || (32'(digit_q[2]) <= HR_UNITS_MAX_AT_20)) &&
                      (32'(digit_q[1]) <= MIN_TENS_MAX);
  end else begin : g_no_range
    assign range_ok = 1'b1;
  end
`else
  assign range_ok = 1'b1;
`endif

  // Priority: clear > commit > backspace > key_valid > inactivity expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      digit_q      <= '0;
      load_q       <= '0;
      count_q      <= '0;
      load_valid_q <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
      if (kb.clear) begin
        digit_q <= '0;
        count_q <= '0;
        state   <= IDLE;
      end else if (kb.commit) begin
        if (count_q == FULL && range_ok) begin
          load_valid_q <= 1'b1;
          load_q       <= digit_q;
          digit_q      <= '0;
          count_q      <= '0;
          state        <= IDLE;
        end else begin
          error_q <= 1'b1;
        end
      end else if (kb.backspace) begin
        digit_q <= {{DIGIT_W{1'b0}}, digit_q[NUM_DIGITS-1:1]};
        if (count_q != '0) count_q <= count_q - CNT_W'(1);
        if (count_q <= CNT_W'(1)) state <= IDLE;
      end else if (kb.key_valid) begin
        if (!is_bcd(32'(kb.key))) begin
          error_q <= 1'b1;
        end else begin
          // Full buffer keeps shifting; the oldest digit falls off the top.
          digit_q <= {digit_q[NUM_DIGITS-2:0], kb.key};
          if (count_q != FULL) count_q <= count_q + CNT_W'(1);
          state <= ENTRY;
        end
      end else if (expire) begin
        timeout_q <= 1'b1;
        digit_q   <= '0;
        count_q   <= '0;
        state     <= IDLE;
      end
    end
  end

  assign kb.digits       = digit_q;
  assign kb.count        = count_q;
  assign kb.entry_active = (state == ENTRY);
  assign kb.load_valid   = load_valid_q;
  assign kb.load_digits  = load_q;
  assign kb.error        = error_q;
  assign kb.timeout      = timeout_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// tb/tb_key_entry_buffer.sv - directed plan plus random strobes against a digit-list reference model
module tb_key_entry_buffer;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_entry_buffer_if #(.NUM_DIGITS(N), .DIGIT_W(DW)) ifc ();

  key_entry_buffer #(
    .NUM_DIGITS (N),
    .DIGIT_W    (DW),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kb   (ifc)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: entered digits as a list, oldest first; newest is digit 0.
  int          q[$];
  bit          m_entry;
  int          quiet;
  int unsigned e_load;
  bit          e_lv, e_err, e_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_value();
    int unsigned v = 0;
    foreach (q[i]) v = (v << 4) | q[i];
    return v;
  endfunction

  function automatic bit m_range_ok();
`ifdef TIME_RANGE_CHECK_EN
    int hh = q[0] * 10 + q[1];
    int mm = q[2] * 10 + q[3];
    return (hh <= 23) && (mm <= 59);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input bit rst, input int k, input bit kv, input bit bs, input bit cl, input bit cm);
    e_lv = 0; e_err = 0; e_to = 0;
    if (rst) begin
      q.delete(); m_entry = 0; quiet = 0; e_load = 0;
      return;
    end
    if (cl) begin
      q.delete(); m_entry = 0;
    end else if (cm) begin
      if (q.size() == N && m_range_ok()) begin
        e_lv = 1; e_load = m_value(); q.delete(); m_entry = 0;
      end else e_err = 1;
    end else if (bs) begin
      if (q.size() > 0) void'(q.pop_back());
      if (q.size() == 0) m_entry = 0;
    end else if (kv) begin
      if (k > 9) e_err = 1;
      else begin
        q.push_back(k);
        if (q.size() > N) void'(q.pop_front());
        m_entry = 1;
      end
    end else if (m_entry) begin
      if (quiet == T - 1) begin
        e_to = 1; q.delete(); m_entry = 0;
      end else quiet++;
    end
    if (kv || bs || cl || cm || !m_entry) quiet = 0;
  endtask

  task automatic check_all();
    check_eq("digits", ifc.digits, m_value());
    check_eq("count", ifc.count, q.size());
    check_eq("entry_active", ifc.entry_active, m_entry);
    check_eq("load_valid", ifc.load_valid, e_lv);
    check_eq("load_digits", ifc.load_digits, e_load);
    check_eq("error", ifc.error, e_err);
    check_eq("timeout", ifc.timeout, e_to);
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input bit rst, input int k, input bit kv, input bit bs, input bit cl, input bit cm);
    reset         = rst;
    ifc.key       = 4'(k);
    ifc.key_valid = kv;
    ifc.backspace = bs;
    ifc.clear     = cl;
    ifc.commit    = cm;
    model_step(rst, k, kv, bs, cl, cm);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic key_in(input int k);  step(0, k, 1, 0, 0, 0); endtask
  task automatic idle();               step(0, 0, 0, 0, 0, 0); endtask
  task automatic do_commit();          step(0, 0, 0, 0, 0, 1); endtask
  task automatic do_bs();              step(0, 0, 0, 1, 0, 0); endtask

  initial begin
    int r, k;
    bit kv, bs, cl, cm, rst;
    reset = 1'b1;
    ifc.key = '0; ifc.key_valid = 0; ifc.backspace = 0; ifc.clear = 0; ifc.commit = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);

    // Plan 1
    key_in(1); key_in(2); key_in(3); key_in(0);
    check_eq("t1_count4", ifc.count, 4);
    do_commit();
    check_eq("t1_load", ifc.load_digits, 32'h1230);
    check_eq("t1_lv", ifc.load_valid, 1);

    // Plan 2
    key_in(1); key_in(2); key_in(3); key_in(4); key_in(5);
    do_commit();
    check_eq("t2_load", ifc.load_digits, 32'h2345);
    check_eq("t2_err", ifc.error, 0);

    // Plan 3
    key_in(1); key_in(2); do_bs();
    check_eq("t3_digits", ifc.digits, 32'h0001);
    do_bs();
    check_eq("t3_idle", ifc.entry_active, 0);
    do_bs();
    check_eq("t3_noerr", ifc.error, 0);

    // Plan 4
    key_in(3); key_in(4); key_in(4'hA);
    check_eq("t4_err", ifc.error, 1);
    idle();
    do_commit();
    check_eq("t4_commit_err", ifc.error, 1);
    check_eq("t4_retained", ifc.digits, 32'h0034);
    step(0, 0, 0, 0, 1, 0);

    // Plan 5: expiry exactly T cycles after the key, then a strobe in the expiry cycle
    key_in(7);
    repeat (T - 1) idle();
    check_eq("t5_not_yet", ifc.timeout, 0);
    idle();
    check_eq("t5_timeout", ifc.timeout, 1);
    check_eq("t5_cleared", ifc.digits, 0);
    key_in(7);
    repeat (T - 1) idle();
    key_in(8);
    check_eq("t5_rescued", ifc.timeout, 0);
    check_eq("t5_digits", ifc.digits, 32'h0078);
    step(0, 0, 0, 0, 1, 0);

    // Plan 6
    key_in(2); key_in(4); key_in(0); key_in(0); do_commit();
    step(0, 0, 0, 0, 1, 0);
    key_in(2); key_in(3); key_in(5); key_in(9); do_commit();
    check_eq("t6_load", ifc.load_digits, 32'h2359);
    key_in(1); key_in(2); key_in(3); key_in(4);
    step(0, 0, 0, 0, 1, 1);
    check_eq("t6_clr_lv", ifc.load_valid, 0);
    check_eq("t6_clr_cnt", ifc.count, 0);
    key_in(1); key_in(1); key_in(1);
    step(1, 1, 1, 0, 0, 1);
    check_eq("reset_mid_load", ifc.load_digits, 0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 9);
      kv = 0; bs = 0; cl = 0; cm = 0; rst = 0;
      if (r < 35) begin
      end else if (r < 68) kv = 1;
      else if (r < 71) begin kv = 1; k = $urandom_range(10, 15); end
      else if (r < 79) bs = 1;
      else if (r < 82) cl = 1;
      else if (r < 93) cm = 1;
      else if (r < 99) begin
        kv = 1'($urandom); bs = 1'($urandom); cl = 1'($urandom); cm = 1'($urandom);
      end else begin
        rst = 1; cm = 1'($urandom);
      end
      step(rst, k, kv, bs, cl, cm);
      if (n % 150 == 75) repeat ($urandom_range(T - 2, T + 2)) idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
